// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - shared state encodings and BCD limits for the stopwatch
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } sw_state_t;

  localparam logic [3:0] BCD_LIMIT_9 = 4'd9;
  localparam logic [3:0] BCD_LIMIT_5 = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit with wrap at limit and combinational carry-out
module bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  input  logic [3:0] limit,
  output logic [3:0] digit,
  output logic       carry
);

  assign carry = inc && (digit == limit);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= carry ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - mm:ss stopwatch: command edges, run/pause FSM, prescaler, BCD cascade
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  localparam int DIV = CLK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("stopwatch_ctrl: CLK_HZ must be at least 2");
  end

  sw_state_t     state_q, state_d;
  logic [PW-1:0] presc_q;
  logic          ss_q, clr_q, armed_q;
  logic          ss_edge, clr_edge;
  logic          c_so, c_st, c_mo;

  // armed_q masks the first cycle after reset so a command already high at release is not an edge
  assign ss_edge  = armed_q && start_stop && !ss_q;
  assign clr_edge = armed_q && clear && !clr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ss_q    <= 1'b0;
      clr_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      ss_q    <= start_stop;
      clr_q   <= clear;
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ss_edge) state_d = S_RUN;
      S_RUN:   if (ss_edge) state_d = S_PAUSE;
      S_PAUSE: if (ss_edge) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    if (clr_edge) begin
      state_d = S_IDLE;
    end
  end

  // held in PAUSE so a resume finishes the interrupted second
  always_ff @(posedge clk) begin
    if (reset || clr_edge) begin
      presc_q <= '0;
    end else if (state_q == S_RUN) begin
      presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    end
  end

  assign running = (state_q == S_RUN);
  assign tick    = !reset && !clr_edge && (state_q == S_RUN) && (presc_q == PRESC_MAX);

  bcd_digit u_sec_ones (
    .clk(clk), .reset(reset), .clr(clr_edge), .inc(tick),
    .limit(BCD_LIMIT_9), .digit(sec_ones), .carry(c_so)
  );

  bcd_digit u_sec_tens (
    .clk(clk), .reset(reset), .clr(clr_edge), .inc(c_so),
    .limit(BCD_LIMIT_5), .digit(sec_tens), .carry(c_st)
  );

  bcd_digit u_min_ones (
    .clk(clk), .reset(reset), .clr(clr_edge), .inc(c_st),
    .limit(BCD_LIMIT_9), .digit(min_ones), .carry(c_mo)
  );

  bcd_digit u_min_tens (
    .clk(clk), .reset(reset), .clr(clr_edge), .inc(c_mo),
    .limit(BCD_LIMIT_5), .digit(min_tens), .carry(wrap)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl against an elapsed-seconds model
module tb_stopwatch_ctrl;

  localparam int DIV = 4;

  logic       clk, reset, start_stop, clear;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, tick, wrap;

  int n_assert = 0;
  int n_fail   = 0;

  // model: mode 0 idle, 1 run, 2 pause; elapsed time kept as plain seconds
  int m_mode, m_pre, m_secs;
  bit m_ss_prev, m_clr_prev, m_armed;

  stopwatch_ctrl #(.CLK_HZ(DIV)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .tick(tick), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit ss_e, clr_e, exp_tick, exp_wrap;
    ss_e     = m_armed && start_stop && !m_ss_prev;
    clr_e    = m_armed && clear && !m_clr_prev;
    exp_tick = !reset && !clr_e && m_mode == 1 && m_pre == DIV - 1;
    exp_wrap = exp_tick && m_secs == 3599;
    chk("sec_ones", sec_ones, 4'(m_secs % 10));
    chk("sec_tens", sec_tens, 4'((m_secs / 10) % 6));
    chk("min_ones", min_ones, 4'((m_secs / 60) % 10));
    chk("min_tens", min_tens, 4'(m_secs / 600));
    chk("running", {3'b0, running}, {3'b0, m_mode == 1});
    chk("tick", {3'b0, tick}, {3'b0, exp_tick});
    chk("wrap", {3'b0, wrap}, {3'b0, exp_wrap});
    if (ss_e && clr_e) begin end
  endtask

  task automatic model_update(input bit ss, input bit cl, input bit rs);
    bit ss_e, clr_e;
    ss_e  = m_armed && ss && !m_ss_prev;
    clr_e = m_armed && cl && !m_clr_prev;
    if (rs) begin
      m_mode = 0; m_pre = 0; m_secs = 0;
      m_ss_prev = 0; m_clr_prev = 0; m_armed = 0;
    end else begin
      if (clr_e) begin
        m_mode = 0; m_pre = 0; m_secs = 0;
      end else begin
        if (m_mode == 1) begin
          if (m_pre == DIV - 1) begin
            m_pre  = 0;
            m_secs = (m_secs + 1) % 3600;
          end else begin
            m_pre++;
          end
        end
        if (ss_e) m_mode = (m_mode == 1) ? 2 : 1;
      end
      m_ss_prev = ss; m_clr_prev = cl; m_armed = 1;
    end
  endtask

  task automatic step(input bit ss, input bit cl, input bit rs);
    start_stop = ss; clear = cl; reset = rs;
    #2;
    check_all();
    @(posedge clk);
    model_update(ss, cl, rs);
    #1;
  endtask

  initial begin
    int guard;
    reset = 1'b1; start_stop = 1'b0; clear = 1'b0;
    m_mode = 0; m_pre = 0; m_secs = 0; m_ss_prev = 0; m_clr_prev = 0; m_armed = 0;
    @(posedge clk); #1;
    repeat (3) step(0, 0, 1);
    repeat (2) step(0, 0, 0);

    // start, then let three seconds elapse
    step(1, 0, 0);
    step(0, 0, 0);
    repeat (14) step(0, 0, 0);

    // pause at different prescaler phases, wait, resume
    for (int ph = 0; ph < DIV; ph++) begin
      guard = 0;
      while (m_pre != ph && guard < 10) begin step(0, 0, 0); guard++; end
      step(1, 0, 0);
      repeat (6) step(0, 0, 0);
      step(1, 0, 0);
      repeat (5) step(0, 0, 0);
    end

    // clear and start_stop on the same cycle while running
    step(1, 1, 0);
    repeat (3) step(0, 0, 0);

    // start_stop held high: exactly one transition
    repeat (20) step(1, 0, 0);
    step(0, 0, 0);

    // run up to 59:58 and across the wrap
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    guard = 0;
    while (m_secs != 3598 && guard < 20000) begin step(0, 0, 0); guard++; end
    n_assert++;
    assert (m_secs == 3598) else begin
      n_fail++;
      $error("FAIL reach_5958 observed=%0d expected=%0d", m_secs, 3598);
    end
    repeat (12) step(0, 0, 0);

    // reset mid-second at 00:09 with start_stop high across release
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    guard = 0;
    while (!(m_secs == 9 && m_pre == 2) && guard < 100) begin step(0, 0, 0); guard++; end
    step(1, 0, 1);
    step(1, 0, 1);
    repeat (5) step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (6) step(0, 0, 0);

    // random commands with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 40) == 0), ($urandom_range(0, 150) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz; prescaler divide ratio DIV = CLK_HZ; DIV >= 2 enforced by elaboration check.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_stop  input  1  synchronous command; acted on at its rising edge only.
REQ-005 SHALL have port clear  input  1  synchronous command; acted on at its rising edge only.
REQ-006 SHALL have port sec_ones  output  4  BCD seconds units, 0-9.
REQ-007 SHALL have port sec_tens  output  4  BCD seconds tens, 0-5.
REQ-008 SHALL have port min_ones  output  4  BCD minutes units, 0-9.
REQ-009 SHALL have port min_tens  output  4  BCD minutes tens, 0-5.
REQ-010 SHALL have port running  output  1  high while in RUN.
REQ-011 SHALL have port tick  output  1  one-cycle pulse on each one-second increment.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse when 59:59 rolls to 00:00.

Function
REQ-013 SHALL detect command edges with a one-cycle registered copy of each command input; a held level SHALL count as one command.
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE.
REQ-015 SHALL transition IDLE->RUN, RUN->PAUSE and PAUSE->RUN on a start_stop edge.
REQ-016 SHALL transition any state->IDLE on a clear edge, zeroing all digits and the prescaler in the same cycle.
REQ-017 SHALL give clear priority over start_stop when both edges occur in the same cycle; the result SHALL be IDLE.
REQ-018 SHALL drive running = 1 exactly when the state is RUN, registered, updating the cycle after the command edge.
REQ-019 SHALL increment the prescaler (width ceil(log2(DIV))) only in RUN, counting 0..DIV-1 and wrapping to 0.
REQ-020 SHALL assert tick for the single cycle in which prescaler == DIV-1 in RUN; the digits SHALL advance on that same edge.
REQ-021 SHALL hold the prescaler value in PAUSE, so a resume completes the partial second rather than restarting it.
REQ-022 SHALL form a BCD cascade on tick: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens; min_tens 5->0 at 59:59 produces 00:00.
REQ-023 SHALL assert wrap on the same edge as the tick that produces 00:00 from 59:59.
REQ-024 SHALL never let digits exceed their maximum; no binary-to-BCD conversion is permitted.
REQ-025 SHALL not advance the digits or assert tick/wrap in IDLE or PAUSE.
REQ-026 SHALL treat a start_stop edge coinciding with a tick in RUN as follows: the tick increment completes, then the state becomes PAUSE.

Reset
REQ-027 SHALL on reset set state IDLE, all digits 0, prescaler 0, running/tick/wrap 0, and edge-detect registers 0.
REQ-028 SHALL give reset priority over all commands and ticks; reset mid-count SHALL discard the elapsed time.
REQ-029 SHALL not detect a command edge in the first cycle after reset if the command is already high at reset release.

Structure
REQ-030 SHALL place state encodings (IDLE, RUN, PAUSE) and BCD limit constants (9, 5) in the shared project package.
REQ-031 SHALL instantiate a sub-module bcd_digit four times, each with ports clk, reset, clr, inc, limit, digit[3:0], carry; carry SHALL be combinational (inc && digit == limit).
REQ-032 SHALL keep the FSM, edge detection and prescaler in stopwatch_ctrl.

Verification (CLK_HZ=4)
REQ-033 SHALL cover: reset, then start_stop edge -> running=1 next cycle; tick every 4 cycles; sec_ones=3 after 12 cycles.
REQ-034 SHALL cover: RUN with prescaler at 2, then start_stop -> PAUSE with digits and prescaler frozen; resume -> first tick after 2 more cycles.
REQ-035 SHALL cover: preload by running to 59:58, then two ticks -> 59:59, then 00:00 with wrap=1 for exactly one cycle.
REQ-036 SHALL cover: clear and start_stop edges in the same cycle during RUN -> IDLE with all digits 0 and running=0.
REQ-037 SHALL cover: start_stop held high for 20 cycles from IDLE -> a single transition to RUN, no toggling.
REQ-038 SHALL cover: reset asserted at 00:09 mid-second -> all outputs 0 next cycle; start_stop high at reset release -> remains IDLE.
